// File: rtl/s_rca24_rr_arb_if.sv
// Request/response bundle for s_rca24_rr_arb.
//   master : requesters and result consumer (drive req_valid/req_a/req_b/rsp_ready)
//   slave  : the arbiter/adder block (drives req_ready and the rsp_* result)
// req_a/req_b pack requester i into bits [24*i+23 : 24*i].
interface s_rca24_rr_arb_if #(
    parameter int unsigned N_REQ = 4
);
    localparam int unsigned DATA_W = 24;
    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [SUM_W-1:0]        rsp_sum;
    logic [ID_W-1:0]         rsp_id;
    logic                    rsp_ovf;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, rsp_ovf
    );
endinterface

// File: rtl/s_rca24_rr_arb.sv
// N_REQ requesters share one signed 24-bit ripple-carry adder through a
// round-robin arbiter; the winner's 25-bit exact sum lands in a single
// result register (latency 1, one result per cycle under rsp_ready=1).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : s_rca24_rr_arb_if.slave
//                req_valid/req_ready/req_a/req_b  requester side
//                rsp_valid/rsp_ready/rsp_sum/rsp_id/rsp_ovf  result side
module s_rca24_rr_arb #(
    parameter int unsigned N_REQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    s_rca24_rr_arb_if.slave   bus
);
    localparam int unsigned DATA_W = 24;
    localparam int unsigned SUM_W  = DATA_W + 1;
    localparam int unsigned ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic              load;

    logic [ID_W-1:0]   last_grant_q;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   scan_idx;
    logic              grant_found;
    logic              can_accept;
    logic              grant;
    logic [N_REQ-1:0]  req_ready_c;

    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W:1]   carry;
    logic [SUM_W-1:0]  sum_c;

    logic [SUM_W-1:0]  rsp_sum_q;
    logic [ID_W-1:0]   rsp_id_q;
    logic              rsp_ovf_q;

    // Position k steps after base, wrapping at N_REQ (need not be a power of two).
    function automatic logic [ID_W-1:0] rr_index(input logic [ID_W-1:0] base,
                                                 input int unsigned     k);
        return ID_W'((32'(base) + k) % N_REQ);
    endfunction

    // Round-robin scan starting just after the last accepted grant.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            scan_idx = rr_index(last_grant_q, k);
            if (!grant_found && bus.req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    assign can_accept = (state_q == EMPTY) || bus.rsp_ready;
    assign grant      = can_accept && grant_found;

    // One-hot ready for the winner; forced low while reset is held.
    always_comb begin
        req_ready_c = '0;
        if (grant && rst_n) begin
            req_ready_c[grant_idx] = 1'b1;
        end
    end

    assign bus.req_ready = req_ready_c;

    // Only the winner's operands reach the shared adder.
    assign op_a = bus.req_a[32'(grant_idx) * DATA_W +: DATA_W];
    assign op_b = bus.req_b[32'(grant_idx) * DATA_W +: DATA_W];

    // Ripple-carry adder: half adder at bit 0, full adders above.
    assign sum_c[0]  = op_a[0] ^ op_b[0];
    assign carry[1]  = op_a[0] & op_b[0];

    for (genvar i = 1; i < DATA_W; i++) begin : g_fa
        assign sum_c[i]     = op_a[i] ^ op_b[i] ^ carry[i];
        assign carry[i+1]   = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end

    // Sign-extended operands make bit 24 the XOR of both sign bits and the last carry.
    assign sum_c[DATA_W] = op_a[DATA_W-1] ^ op_b[DATA_W-1] ^ carry[DATA_W];

    // Result-register state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and load strobe for the result register.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (grant) begin
                    state_d = FULL;
                    load    = 1'b1;
                end
            end
            FULL: begin
                if (bus.rsp_ready) begin
                    if (grant) begin
                        load = 1'b1;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Result payload and arbitration pointer; both move only on an accepted grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_sum_q    <= '0;
            rsp_id_q     <= '0;
            rsp_ovf_q    <= 1'b0;
            last_grant_q <= ID_W'(N_REQ - 1);
        end else if (load) begin
            rsp_sum_q    <= sum_c;
            rsp_id_q     <= grant_idx;
            rsp_ovf_q    <= sum_c[DATA_W] ^ sum_c[DATA_W-1];
            last_grant_q <= grant_idx;
        end
    end

    assign bus.rsp_valid = (state_q == FULL);
    assign bus.rsp_sum   = rsp_sum_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_s_rca24_rr_arb.sv
`timescale 1ns/1ps
module tb_s_rca24_rr_arb;
    localparam int N      = 4;
    localparam int N_RAND = 30000;

    logic clk;
    logic rst_n;
    int   pass_cnt;
    int   total_cnt;

    s_rca24_rr_arb_if #(.N_REQ(N)) bus ();

    s_rca24_rr_arb #(.N_REQ(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the result register should hold.
    bit          m_full;
    logic [24:0] m_sum;
    int          m_id;
    bit          m_ovf;
    int          m_last;

    function automatic void ref_add(input logic [23:0] a, input logic [23:0] b,
                                    output logic [24:0] s, output bit ovf);
        int total;
        total = int'($signed(a)) + int'($signed(b));
        s     = 25'(total);
        ovf   = (total > 8388607) || (total < -8388608);
    endfunction

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        int p;
        r = '0;
        p = rr_pick(bus.req_valid, m_last);
        if (rst_n && (!m_full || bus.rsp_ready) && p >= 0) r[p] = 1'b1;
        return r;
    endfunction

    function automatic logic [23:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 24'h7FFFFF;
            1:       return 24'h800000;
            2:       return 24'hFFFFFF;
            3:       return 24'h000000;
            default: return 24'($urandom);
        endcase
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_sum  = '0;
        m_id   = 0;
        m_ovf  = 1'b0;
        m_last = N - 1;
    endtask

    task automatic set_op(input int i, input logic [23:0] a, input logic [23:0] b);
        bus.req_a[24*i +: 24] = a;
        bus.req_b[24*i +: 24] = b;
    endtask

    // Advance one clock: sample inputs before the edge, update the model, stop at negedge.
    task automatic tick();
        int          p;
        bit          can;
        logic [23:0] a;
        logic [23:0] b;
        bit          rr;
        rr  = bus.rsp_ready;
        can = !m_full || rr;
        p   = rr_pick(bus.req_valid, m_last);
        a   = '0;
        b   = '0;
        if (p >= 0) begin
            a = bus.req_a[24*p +: 24];
            b = bus.req_b[24*p +: 24];
        end
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else if (can && p >= 0) begin
            m_full = 1'b1;
            ref_add(a, b, m_sum, m_ovf);
            m_id   = p;
            m_last = p;
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, rand_op(), rand_op());
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.rsp_valid);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_sum !== 25'h0) $display("FAIL reset_sum: got %h want 0", bus.rsp_sum);
        else pass_cnt++;
        total_cnt++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_ovf !== 1'b0)
            $display("FAIL reset_id_ovf: got %0d/%b want 0/0", bus.rsp_id, bus.rsp_ovf);
        else pass_cnt++;
        total_cnt++;
        if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", bus.req_ready);
        else pass_cnt++;
        bus.req_valid = '0;
        rst_n         = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        bus.req_valid = 4'b0001;
        set_op(0, 24'h7FFFFF, 24'h000001);
        bus.rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0001) $display("FAIL single_ready: got %b want 0001", bus.req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== 25'h0800000 || bus.rsp_id !== 2'd0 || bus.rsp_ovf !== 1'b1)
            $display("FAIL single_rsp: got v=%b sum=%h id=%0d ovf=%b want v=1 sum=0800000 id=0 ovf=1",
                     bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.rsp_ovf);
        else pass_cnt++;
        bus.req_valid = '0;
        tick();
        total_cnt++;
        if (bus.rsp_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", bus.rsp_valid);
        else pass_cnt++;
    endtask

    task automatic test_negative();
        bus.req_valid = 4'b0100;
        set_op(2, 24'h800000, 24'h800000);
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0100) $display("FAIL neg_ready: got %b want 0100", bus.req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.rsp_sum !== 25'h1000000 || bus.rsp_ovf !== 1'b1 || bus.rsp_id !== 2'd2)
            $display("FAIL neg_min: got sum=%h ovf=%b id=%0d want 1000000/1/2", bus.rsp_sum, bus.rsp_ovf, bus.rsp_id);
        else pass_cnt++;
        set_op(2, 24'hFFFFFF, 24'h000001);
        tick();
        total_cnt++;
        if (bus.rsp_sum !== 25'h0 || bus.rsp_ovf !== 1'b0 || bus.rsp_valid !== 1'b1)
            $display("FAIL neg_zero: got sum=%h ovf=%b v=%b want 0/0/1", bus.rsp_sum, bus.rsp_ovf, bus.rsp_valid);
        else pass_cnt++;
        bus.req_valid = '0;
        tick();
    endtask

    task automatic test_fairness();
        int w;
        rst_n = 1'b0;
        #1;
        model_reset();
        @(negedge clk);
        rst_n         = 1'b1;
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, rand_op(), rand_op());
        for (int k = 0; k < 12; k++) begin
            w = k % N;
            #1;
            total_cnt++;
            if (bus.req_ready !== N'(1 << w))
                $display("FAIL fair_ready[%0d]: got %b want %b", k, bus.req_ready, N'(1 << w));
            else pass_cnt++;
            tick();
            total_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(w) || bus.rsp_sum !== m_sum)
                $display("FAIL fair_rsp[%0d]: got v=%b id=%0d sum=%h want 1/%0d/%h",
                         k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, w, m_sum);
            else pass_cnt++;
            set_op(w, rand_op(), rand_op());
        end
    endtask

    task automatic test_backpressure();
        logic [24:0] e_sum;
        int          e_id;
        bit          e_ovf;
        e_sum = m_sum;
        e_id  = m_id;
        e_ovf = m_ovf;
        bus.rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            total_cnt++;
            if (bus.req_ready !== 4'b0000) $display("FAIL bp_ready[%0d]: got %b want 0000", k, bus.req_ready);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_sum !== e_sum || bus.rsp_id !== 2'(e_id) || bus.rsp_ovf !== e_ovf)
                $display("FAIL bp_hold[%0d]: got v=%b sum=%h id=%0d ovf=%b want 1/%h/%0d/%b",
                         k, bus.rsp_valid, bus.rsp_sum, bus.rsp_id, bus.rsp_ovf, e_sum, e_id, e_ovf);
            else pass_cnt++;
        end
        bus.rsp_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.req_ready !== 4'b0001) $display("FAIL bp_release: got %b want 0001", bus.req_ready);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (bus.rsp_id !== 2'd0 || bus.rsp_sum !== m_sum)
            $display("FAIL bp_next: got id=%0d sum=%h want 0/%h", bus.rsp_id, bus.rsp_sum, m_sum);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bus.rsp_ready = 1'b0;
        rst_n         = 1'b0;
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 25'h0 || bus.req_ready !== 4'b0000)
            $display("FAIL midrst_async: got v=%b sum=%h rdy=%b want 0/0/0000",
                     bus.rsp_valid, bus.rsp_sum, bus.req_ready);
        else pass_cnt++;
        model_reset();
        @(negedge clk);
        bus.req_valid = 4'b1010;
        rst_n         = 1'b1;
        #1;
        total_cnt++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 4'b0010)
            $display("FAIL midrst_release: got v=%b rdy=%b want 0/0010", bus.rsp_valid, bus.req_ready);
        else pass_cnt++;
        bus.rsp_ready = 1'b1;
        tick();
        total_cnt++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== m_sum)
            $display("FAIL midrst_first: got v=%b id=%0d sum=%h want 1/1/%h",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_sum, m_sum);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [N-1:0] e_rdy;
        for (int cyc = 0; cyc < N_RAND; cyc++) begin
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            e_rdy = exp_ready();
            total_cnt++;
            if (bus.req_ready !== e_rdy)
                $display("FAIL rand_ready[%0d]: got %b want %b", cyc, bus.req_ready, e_rdy);
            else pass_cnt++;
            tick();
            total_cnt++;
            if (bus.rsp_valid !== m_full)
                $display("FAIL rand_valid[%0d]: got %b want %b", cyc, bus.rsp_valid, m_full);
            else pass_cnt++;
            if (m_full) begin
                total_cnt++;
                if (bus.rsp_sum !== m_sum || bus.rsp_id !== 2'(m_id) || bus.rsp_ovf !== m_ovf)
                    $display("FAIL rand_rsp[%0d]: got sum=%h id=%0d ovf=%b want %h/%0d/%b",
                             cyc, bus.rsp_sum, bus.rsp_id, bus.rsp_ovf, m_sum, m_id, m_ovf);
                else pass_cnt++;
            end
            // Requesters hold operands until accepted; idle or just-accepted ones may change.
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] || e_rdy[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 2) != 0);
                    set_op(i, rand_op(), rand_op());
                end
            end
        end
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_single();
        test_negative();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
